user_pixel_mem: RTL and testbench

- Image pixel store that sits directly upstream of the Sobel edge-detect stage and serves its 3x3 window fetches.
- The CPU loads a 16x16 8-bit greyscale image over an OBI slave port.
- The edge stage reads single pixels over a req/addr/valid port.
- The store is one single-port byte array, shared between the two ports with fixed priority.

---
 rtl/user_pkg.sv | 48 ++++
 rtl/user_pixel_sram.sv | 49 ++++
 rtl/user_pixel_mem.sv | 134 +++++++++++++
 tb/tb_user_pixel_mem.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/user_pkg.sv
// Shared user-domain constants and OBI payload types for the pixel store
// and the downstream edge stage.
package user_pkg;

    localparam int unsigned ObiAddrW = 32;
    localparam int unsigned ObiDataW = 32;
    localparam int unsigned ObiIdW   = 1;

    localparam logic [31:0] UserPixMemAddrOffset = 32'h2000_8000;
    localparam logic [31:0] UserPixMemAddrRange  = 32'h0000_0400;

    localparam int unsigned ImgWidthDefault  = 16;
    localparam int unsigned ImgHeightDefault = 16;

    localparam logic [9:0] PixArrayOffset = 10'h000;
    localparam logic [9:0] FetchCntOffset = 10'h100;

    typedef struct packed {
        logic [ObiAddrW-1:0] addr;
        logic                we;
        logic [3:0]          be;
        logic [ObiDataW-1:0] wdata;
        logic [ObiIdW-1:0]   aid;
    } user_obi_a_t;

    typedef struct packed {
        logic        req;
        user_obi_a_t a;
    } user_obi_req_t;

    typedef struct packed {
        logic [ObiDataW-1:0] rdata;
        logic [ObiIdW-1:0]   rid;
        logic                err;
    } user_obi_r_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        user_obi_r_t r;
    } user_obi_rsp_t;

    // Little-endian byte lane extraction from a 32-bit word.
    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/user_pixel_sram.sv
// Byte-enabled single-port word array with a registered read port.
module user_pixel_sram
    import user_pkg::*;
#(
    parameter int unsigned NumWords = 64,
    parameter int unsigned AddrW    = $clog2(NumWords)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [AddrW-1:0]    addr_i,
    input  logic [3:0]          be_i,
    input  logic [ObiDataW-1:0] wdata_i,
    output logic [ObiDataW-1:0] rdata_o
);

    logic [ObiDataW-1:0] mem_q [NumWords];
    logic [ObiDataW-1:0] rdata_d, rdata_q;

    // Storage is deliberately left unreset so it can map onto a macro.
    always_ff @(posedge clk_i) begin
        if (req_i && we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (req_i && !we_i) begin
            rdata_d = mem_q[addr_i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/user_pixel_mem.sv
// Pixel store shared between a CPU OBI port and the Sobel window fetch port;
// the pixel port wins the single array port on conflict.
module user_pixel_mem
    import user_pkg::*;
#(
    parameter type         obi_req_t   = user_obi_req_t,
    parameter type         obi_rsp_t   = user_obi_rsp_t,
    parameter int unsigned ImgWidth    = ImgWidthDefault,
    parameter int unsigned ImgHeight   = ImgHeightDefault,
    parameter logic [7:0]  BorderValue = 8'h00
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  obi_req_t    obi_req_i,
    output obi_rsp_t    obi_rsp_o,
    input  logic        pix_req_i,
    input  logic [15:0] pix_addr_i,
    output logic [31:0] pix_data_o,
    output logic        pix_valid_o
);

    localparam int unsigned NumPix   = ImgWidth * ImgHeight;
    localparam int unsigned NumWords = NumPix / 4;
    localparam int unsigned WordAw   = $clog2(NumWords);
    localparam logic [9:0]  ArrEnd   = PixArrayOffset + 10'(NumPix);

    logic [9:0]          obi_off;
    logic                obi_is_arr, obi_is_cnt, obi_gnt;
    logic                pix_accept, pix_in_img;
    logic                sram_req, sram_we;
    logic [WordAw-1:0]   sram_addr;
    logic [ObiDataW-1:0] sram_rdata;
    logic [7:0]          pix_byte;
    logic                unused_addr;

    logic                pix_valid_d, pix_valid_q;
    logic                pix_border_d, pix_border_q;
    logic [1:0]          pix_bsel_d, pix_bsel_q;
    logic                rvalid_d, rvalid_q;
    logic                err_d, err_q;
    logic [ObiIdW-1:0]   rid_d, rid_q;
    logic                rd_sram_d, rd_sram_q;
    logic [ObiDataW-1:0] rdata_d, rdata_q;
    logic [31:0]         cnt_d, cnt_q;

    assign unused_addr = ^obi_req_i.a.addr[ObiAddrW-1:10];

    // Address decode, arbitration and next-state for response registers.
    always_comb begin
        obi_off      = obi_req_i.a.addr[9:0];
        obi_is_arr   = (obi_off >= PixArrayOffset) && (obi_off < ArrEnd);
        obi_is_cnt   = (obi_off == FetchCntOffset);
        pix_in_img   = (pix_addr_i < 16'(NumPix));
        pix_accept   = pix_req_i && !pix_valid_q;
        obi_gnt      = obi_req_i.req && !(obi_is_arr && pix_accept);

        sram_req     = pix_accept || (obi_gnt && obi_is_arr);
        sram_we      = !pix_accept && obi_req_i.a.we;
        sram_addr    = pix_accept ? pix_addr_i[WordAw+1:2] : obi_off[WordAw+1:2];

        pix_valid_d  = pix_accept;
        pix_border_d = !pix_in_img;
        pix_bsel_d   = pix_addr_i[1:0];

        rvalid_d     = obi_gnt;
        rid_d        = obi_req_i.a.aid;
        err_d        = obi_gnt && !obi_is_arr && !obi_is_cnt;
        rd_sram_d    = obi_gnt && obi_is_arr && !obi_req_i.a.we;
        rdata_d      = '0;
        if (obi_gnt && obi_is_cnt && !obi_req_i.a.we) begin
            rdata_d = cnt_q;
        end

        // A clear wins over a coincident valid pulse.
        cnt_d = cnt_q;
        if (obi_gnt && obi_is_cnt && obi_req_i.a.we) begin
            cnt_d = '0;
        end else if (pix_valid_q) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pix_valid_q  <= 1'b0;
            pix_border_q <= 1'b0;
            pix_bsel_q   <= '0;
            rvalid_q     <= 1'b0;
            err_q        <= 1'b0;
            rid_q        <= '0;
            rd_sram_q    <= 1'b0;
            rdata_q      <= '0;
            cnt_q        <= '0;
        end else begin
            pix_valid_q  <= pix_valid_d;
            pix_border_q <= pix_border_d;
            pix_bsel_q   <= pix_bsel_d;
            rvalid_q     <= rvalid_d;
            err_q        <= err_d;
            rid_q        <= rid_d;
            rd_sram_q    <= rd_sram_d;
            rdata_q      <= rdata_d;
            cnt_q        <= cnt_d;
        end
    end

    user_pixel_sram #(
        .NumWords (NumWords)
    ) u_sram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (sram_req),
        .we_i    (sram_we),
        .addr_i  (sram_addr),
        .be_i    (obi_req_i.a.be),
        .wdata_i (obi_req_i.a.wdata),
        .rdata_o (sram_rdata)
    );

    // Response data is zero outside its strobe so idle outputs stay quiet.
    always_comb begin
        pix_byte    = pix_border_q ? BorderValue : byte_sel(sram_rdata, pix_bsel_q);
        pix_valid_o = pix_valid_q;
        pix_data_o  = pix_valid_q ? {24'd0, pix_byte} : 32'd0;

        obi_rsp_o         = '0;
        obi_rsp_o.gnt     = obi_gnt;
        obi_rsp_o.rvalid  = rvalid_q;
        obi_rsp_o.r.rid   = rid_q;
        obi_rsp_o.r.err   = err_q;
        obi_rsp_o.r.rdata = rd_sram_q ? sram_rdata : rdata_q;
    end

endmodule

// File: tb/tb_user_pixel_mem.sv
// Randomized and directed bench for user_pixel_mem against a byte-array model.
module tb_user_pixel_mem;
    import user_pkg::*;

    localparam logic [7:0] Border = 8'h00;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    user_obi_req_t obi_req;
    user_obi_rsp_t obi_rsp;
    logic          pix_req;
    logic [15:0]   pix_addr;
    logic [31:0]   pix_data;
    logic          pix_valid;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem_m [256];
    logic [31:0] cnt_m;
    logic        exp_pv;
    logic [31:0] exp_pd;
    logic        exp_rv;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_rid;

    user_pixel_mem #(
        .BorderValue (Border)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .obi_req_i   (obi_req),
        .obi_rsp_o   (obi_rsp),
        .pix_req_i   (pix_req),
        .pix_addr_i  (pix_addr),
        .pix_data_o  (pix_data),
        .pix_valid_o (pix_valid)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_idle();
        pix_req     = 1'b0;
        pix_addr    = '0;
        obi_req     = '0;
    endtask

    // Asserts reset before the next edge, so anything set up this cycle is dropped.
    task automatic do_reset();
        rst_i     = 1'b1;
        #1;
        set_idle();
        exp_pv    = 1'b0;
        exp_rv    = 1'b0;
        cnt_m     = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
        chk("rst_pix_data", pix_data, 32'd0);
        chk("rst_rvalid", {31'd0, obi_rsp.rvalid}, 32'd0);
        chk("rst_rdata", obi_rsp.r.rdata, 32'd0);
        chk("rst_err", {31'd0, obi_rsp.r.err}, 32'd0);
        rst_i     = 1'b0;
    endtask

    // One clock: check last cycle's responses, apply new inputs, predict the next.
    task automatic step(input logic preq, input logic [15:0] paddr,
                        input logic oreq, input logic owe, input logic [9:0] ooff,
                        input logic [3:0] obe, input logic [31:0] owd, input logic oid);
        logic accept, is_arr, is_cnt, gnt_e;
        int   w;
        @(posedge clk_i);
        #1;
        chk("pix_valid", {31'd0, pix_valid}, {31'd0, exp_pv});
        if (exp_pv) chk("pix_data", pix_data, exp_pd);
        chk("rvalid", {31'd0, obi_rsp.rvalid}, {31'd0, exp_rv});
        if (exp_rv) begin
            chk("rdata", obi_rsp.r.rdata, exp_rdata);
            chk("err", {31'd0, obi_rsp.r.err}, {31'd0, exp_err});
            chk("rid", {31'd0, obi_rsp.r.rid}, {31'd0, exp_rid});
        end

        pix_req          = preq;
        pix_addr         = paddr;
        obi_req.req      = oreq;
        obi_req.a.we     = owe;
        obi_req.a.addr   = UserPixMemAddrOffset | {22'd0, ooff};
        obi_req.a.be     = obe;
        obi_req.a.wdata  = owd;
        obi_req.a.aid    = oid;
        #1;

        accept = preq && !exp_pv;
        is_arr = int'(ooff) < 256;
        is_cnt = int'(ooff) == 256;
        gnt_e  = oreq && !(is_arr && accept);
        chk("gnt", {31'd0, obi_rsp.gnt}, {31'd0, gnt_e});

        exp_pd    = (int'(paddr) < 256) ? {24'd0, mem_m[paddr[7:0]]} : {24'd0, Border};
        exp_rv    = gnt_e;
        exp_rid   = oid;
        exp_err   = 1'b0;
        exp_rdata = '0;
        if (gnt_e) begin
            w = int'(ooff) / 4;
            if (is_arr) begin
                if (owe) begin
                    for (int b = 0; b < 4; b++)
                        if (obe[b]) mem_m[w*4 + b] = owd[8*b +: 8];
                end else begin
                    exp_rdata = {mem_m[w*4+3], mem_m[w*4+2], mem_m[w*4+1], mem_m[w*4]};
                end
            end else if (is_cnt) begin
                if (!owe) exp_rdata = cnt_m;
            end else begin
                exp_err = 1'b1;
            end
        end
        if (gnt_e && is_cnt && owe) cnt_m = '0;
        else if (exp_pv)            cnt_m = cnt_m + 32'd1;
        exp_pv = accept;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'd0, 1'b0, 1'b0, 10'd0, 4'h0, 32'd0, 1'b0);
    endtask

    task automatic pix_rd(input logic [15:0] a);
        step(1'b1, a, 1'b0, 1'b0, 10'd0, 4'h0, 32'd0, 1'b0);
        idle(1);
    endtask

    task automatic obi_wr(input logic [9:0] off, input logic [3:0] be, input logic [31:0] d);
        step(1'b0, 16'd0, 1'b1, 1'b1, off, be, d, 1'b1);
    endtask

    task automatic obi_rd(input logic [9:0] off);
        step(1'b0, 16'd0, 1'b1, 1'b0, off, 4'hF, 32'd0, 1'b0);
    endtask

    initial begin
        logic [9:0]  roff;
        logic [15:0] raddr;
        int          k;
        set_idle();
        for (int i = 0; i < 256; i++) mem_m[i] = 8'hxx;
        do_reset();

        for (int i = 0; i < 64; i++) obi_wr(10'(i*4), 4'hF, $urandom);

        // Word write then four spaced pixel reads.
        obi_wr(10'h000, 4'hF, 32'h0302_0100);
        for (int a = 0; a < 4; a++) pix_rd(16'(a));

        // Held request yields one pulse every other cycle; counter sees three.
        obi_wr(FetchCntOffset, 4'hF, 32'hFFFF_FFFF);
        for (int i = 0; i < 6; i++) step(1'b1, 16'd5, 1'b0, 1'b0, 10'd0, 4'h0, 32'd0, 1'b0);
        idle(1);
        obi_rd(FetchCntOffset);
        idle(1);
        chk("fetch_cnt_model", cnt_m, 32'd3);

        // Out-of-image addresses.
        pix_rd(16'hFFEF);
        pix_rd(16'h0100);

        // Array read collides with pixel accept, then gets through.
        step(1'b1, 16'd7, 1'b1, 1'b0, 10'h004, 4'hF, 32'd0, 1'b1);
        step(1'b1, 16'd7, 1'b1, 1'b0, 10'h004, 4'hF, 32'd0, 1'b1);
        idle(1);

        // Single byte-lane write followed immediately by a pixel read of it.
        obi_wr(10'h00A, 4'b0100, 32'h00AB_0000);
        pix_rd(16'd10);
        pix_rd(16'd8);
        pix_rd(16'd9);
        pix_rd(16'd11);

        // Reset while a pixel response is pending.
        step(1'b1, 16'd3, 1'b0, 1'b0, 10'd0, 4'h0, 32'd0, 1'b0);
        do_reset();
        idle(1);
        obi_rd(FetchCntOffset);
        obi_rd(10'h200);
        idle(1);

        // Random traffic on both ports.
        for (int i = 0; i < 400; i++) begin
            raddr = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
            k = $urandom_range(0, 11);
            if (k < 7)       roff = 10'($urandom_range(0, 63) * 4);
            else if (k < 10) roff = FetchCntOffset;
            else             roff = 10'h104 + 10'($urandom_range(0, 700));
            step(1'($urandom_range(0, 9) < 6), raddr,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), roff,
                 4'($urandom), $urandom, 1'($urandom));
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
